// File: rtl/abs_encoder_tracker.sv
// abs_encoder_tracker
// Samples a parallel Gray-coded absolute encoder, debounces it, decodes it to
// a binary position and keeps a signed count of full turns across wrap-around.
// Accepted moves larger than MAX_STEP are treated as implausible jumps and
// raise a sticky error instead of being counted as steps.
module abs_encoder_tracker #(
  parameter int WIDTH         = 8,
  parameter int STABLE_CYCLES = 16,
  parameter int MAX_STEP      = 2,
  parameter int TURN_W        = 16,
  parameter int REVERSE_BITS  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  enc_in,
  input  logic              clr_turns,
  input  logic              err_clr,
  output logic [WIDTH-1:0]  pos,
  output logic [TURN_W-1:0] turns,
  output logic              pos_valid,
  output logic              step_pulse,
  output logic              dir,
  output logic              jump_err
);

  localparam int CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [WIDTH:0]   MAX_STEP_W = (WIDTH+1)'(MAX_STEP);

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

  state_t state_reg, state_next;

  logic [WIDTH-1:0]  sync1_reg, sync2_reg;
  logic [WIDTH-1:0]  code;
  logic [WIDTH-1:0]  cand_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [WIDTH-1:0]  stable_reg;
  logic [WIDTH-1:0]  new_pos;
  logic [WIDTH-1:0]  delta;
  logic [WIDTH-1:0]  mag;
  logic              delta_neg;
  logic              step_ok;
  logic              wrap_up;
  logic              wrap_down;
  logic              accept;
  logic              do_acquire;
  logic              do_step;
  logic              do_jump;

  logic [WIDTH-1:0]  pos_reg;
  logic [TURN_W-1:0] turns_reg;
  logic              pos_valid_reg;
  logic              step_pulse_reg;
  logic              dir_reg;
  logic              jump_err_reg;

  // Two-stage synchroniser for the asynchronous contact inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= enc_in;
      sync2_reg <= sync1_reg;
    end
  end

  // Put the Gray MSB at the top regardless of harness wiring order
  generate
    if (REVERSE_BITS != 0) begin : g_rev
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        assign code[gi] = sync2_reg[WIDTH-1-gi];
      end
    end else begin : g_fwd
      assign code = sync2_reg;
    end
  endgenerate

  // Debounce: restart the hold count whenever the synced code moves
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand_reg <= '0;
      cnt_reg  <= '0;
    end else if (code != cand_reg) begin
      cand_reg <= code;
      cnt_reg  <= '0;
    end else if (cnt_reg != CNT_MAX) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  // A held candidate is accepted once, unless it is the first one after reset
  assign accept = (cnt_reg == CNT_MAX) &&
                  ((state_reg == ST_INIT) || (cand_reg != stable_reg));

  // Remember the last accepted code so a settled value is not re-accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_reg <= '0;
    end else if (accept) begin
      stable_reg <= cand_reg;
    end
  end

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_dec
      assign new_pos[gi] = ^cand_reg[WIDTH-1:gi];
    end
  endgenerate

  // Signed modular distance from the current position to the candidate
  assign delta     = new_pos - pos_reg;
  assign delta_neg = delta[WIDTH-1];
  assign mag       = delta_neg ? (-delta) : delta;
  assign step_ok   = (mag != '0) && ({1'b0, mag} <= MAX_STEP_W);
  assign wrap_up   = !delta_neg && (new_pos < pos_reg);
  assign wrap_down = delta_neg && (new_pos > pos_reg);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_INIT;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next state: leave INIT on the first accepted code, then stay tracking
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_INIT:  if (accept) state_next = ST_TRACK;
      ST_TRACK: state_next = ST_TRACK;
      default:  state_next = ST_INIT;
    endcase
  end

  // FSM outputs: classify each accept as acquisition, legal step or jump
  always_comb begin
    do_acquire = 1'b0;
    do_step    = 1'b0;
    do_jump    = 1'b0;
    case (state_reg)
      ST_INIT:  do_acquire = accept;
      ST_TRACK: begin
        do_step = accept && step_ok;
        do_jump = accept && !step_ok;
      end
      default: ;
    endcase
  end

  // Position, direction and step strobe follow the classified accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_reg        <= '0;
      pos_valid_reg  <= 1'b0;
      step_pulse_reg <= 1'b0;
      dir_reg        <= 1'b0;
    end else begin
      step_pulse_reg <= do_step;
      if (do_acquire || do_step || do_jump) pos_reg <= new_pos;
      if (do_acquire) pos_valid_reg <= 1'b1;
      if (do_step) dir_reg <= !delta_neg;
    end
  end

  // Turn counter wraps freely; an explicit clear beats a same-cycle wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      turns_reg <= '0;
    end else if (clr_turns) begin
      turns_reg <= '0;
    end else if (do_step && wrap_up) begin
      turns_reg <= turns_reg + TURN_W'(1);
    end else if (do_step && wrap_down) begin
      turns_reg <= turns_reg - TURN_W'(1);
    end
  end

  // Sticky jump flag; a new jump beats a same-cycle clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      jump_err_reg <= 1'b0;
    end else if (do_jump) begin
      jump_err_reg <= 1'b1;
    end else if (err_clr) begin
      jump_err_reg <= 1'b0;
    end
  end

  assign pos        = pos_reg;
  assign turns      = turns_reg;
  assign pos_valid  = pos_valid_reg;
  assign step_pulse = step_pulse_reg;
  assign dir        = dir_reg;
  assign jump_err   = jump_err_reg;

endmodule

// File: tb/tb_abs_encoder_tracker.sv
// Bench for abs_encoder_tracker: directed scenarios followed by a random walk,
// with every cycle compared against a behavioural model of the tracker.
module tb_abs_encoder_tracker;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  enc_in = 8'h00;
  logic        clr_turns = 1'b0;
  logic        err_clr = 1'b0;
  logic [7:0]  pos;
  logic [15:0] turns;
  logic        pos_valid, step_pulse, dir, jump_err;

  abs_encoder_tracker #(
    .WIDTH(8), .STABLE_CYCLES(S), .MAX_STEP(2), .TURN_W(16), .REVERSE_BITS(0)
  ) dut (
    .clk(clk), .rst(rst), .enc_in(enc_in), .clr_turns(clr_turns),
    .err_clr(err_clr), .pos(pos), .turns(turns), .pos_valid(pos_valid),
    .step_pulse(step_pulse), .dir(dir), .jump_err(jump_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int step_seen = 0;

  // Model state: binary position currently on the pins plus expected outputs
  int          cur = 0;
  int          hist[$];
  bit          m_init;
  int          m_stable;
  int          m_pos;
  logic [15:0] m_turns;
  bit          m_valid, m_step, m_dir, m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, want %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [7:0] gray(input int p);
    int g;
    g = p ^ (p >> 1);
    return g[7:0];
  endfunction

  task automatic set_pos(input int p);
    cur = p & 255;
    enc_in = gray(cur);
  endtask

  task automatic model_reset();
    m_init = 1; m_stable = 0; m_pos = 0; m_turns = '0;
    m_valid = 0; m_step = 0; m_dir = 0; m_err = 0;
    hist.delete();
    repeat (3) hist.push_back(0);
  endtask

  // A value is accepted once it has been seen on S consecutive samples that
  // are two sampling edges old, unless it is already the settled value.
  task automatic model_edge();
    int  sz, v, d, old;
    bit  acc, jump;
    sz = hist.size();
    acc = 0; jump = 0; v = 0;
    if (sz >= S + 2) begin
      v = hist[sz-3];
      acc = 1;
      for (int k = sz - S - 2; k <= sz - 3; k++) if (hist[k] != v) acc = 0;
      if (!m_init && v == m_stable) acc = 0;
    end
    m_step = 0;
    if (acc) begin
      m_stable = v;
      if (m_init) begin
        m_pos = v; m_valid = 1; m_init = 0;
      end else begin
        old = m_pos;
        d = (v - old) & 255;
        if (d >= 128) d = d - 256;
        m_pos = v;
        if (d >= -2 && d <= 2) begin
          m_step = 1;
          m_dir = (d > 0);
          if (d > 0 && v < old) m_turns = m_turns + 16'd1;
          if (d < 0 && v > old) m_turns = m_turns - 16'd1;
        end else begin
          jump = 1;
        end
      end
    end
    if (clr_turns) m_turns = '0;
    if (jump) m_err = 1;
    else if (err_clr) m_err = 0;
    hist.push_back(cur);
    if (hist.size() > S + 4) void'(hist.pop_front());
  endtask

  task automatic check_all();
    check("pos", 32'(pos), 32'(m_pos));
    check("turns", 32'(turns), 32'(m_turns));
    check("pos_valid", 32'(pos_valid), 32'(m_valid));
    check("step_pulse", 32'(step_pulse), 32'(m_step));
    check("dir", 32'(dir), 32'(m_dir));
    check("jump_err", 32'(jump_err), 32'(m_err));
    if (step_pulse === 1'b1) step_seen++;
  endtask

  // One clock: inputs already set, model follows the edge, outputs checked mid-low
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic hold(input int p, input int n);
    set_pos(p);
    repeat (n) cycle();
  endtask

  // Asynchronous reset a few ns into the low phase, released on a later falling edge
  task automatic async_reset(input int edges);
    #3 rst = 1'b1;
    #1 model_reset();
    check_all();
    repeat (edges) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  int base;
  int guard;

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all();

    // T1 acquire gray(5) right after release
    set_pos(5);
    rst = 1'b0;
    model_reset();
    base = step_seen;
    repeat (6) cycle();
    check("t1_not_yet_valid", 32'(pos_valid), 32'd0);
    cycle();
    check("t1_pos", 32'(pos), 32'd5);
    check("t1_valid", 32'(pos_valid), 32'd1);
    check("t1_turns", 32'(turns), 32'd0);
    hold(5, 3);
    check("t1_no_step", 32'(step_seen - base), 32'd0);

    // T2 single steps up and down
    base = step_seen;
    hold(6, 8);
    check("t2_pos_up", 32'(pos), 32'd6);
    check("t2_dir_up", 32'(dir), 32'd1);
    check("t2_one_pulse", 32'(step_seen - base), 32'd1);
    hold(5, 8);
    check("t2_dir_down", 32'(dir), 32'd0);
    check("t2_pos_down", 32'(pos), 32'd5);

    // T4 short glitch is ignored
    hold(6, 8);
    base = step_seen;
    hold(7, 3);
    hold(6, 8);
    check("t4_pos", 32'(pos), 32'd6);
    check("t4_no_step", 32'(step_seen - base), 32'd0);

    // T5 jump, clear, and clear racing a new jump
    hold(8, 8);
    hold(10, 8);
    base = step_seen;
    hold(40, 8);
    check("t5_err", 32'(jump_err), 32'd1);
    check("t5_pos", 32'(pos), 32'd40);
    check("t5_turns", 32'(turns), 32'd0);
    check("t5_no_step", 32'(step_seen - base), 32'd0);
    err_clr = 1'b1; cycle(); err_clr = 1'b0;
    check("t5_err_cleared", 32'(jump_err), 32'd0);
    set_pos(100);
    repeat (6) cycle();
    err_clr = 1'b1; cycle(); err_clr = 1'b0;
    check("t5_set_wins", 32'(jump_err), 32'd1);
    check("t5_pos2", 32'(pos), 32'd100);

    // T3 wrap forwards and back, then clear at three turns
    hold(254, 8);
    hold(255, 8);
    hold(0, 8);
    check("t3_turn_up", 32'(turns), 32'd1);
    hold(255, 8);
    check("t3_turn_back", 32'(turns), 32'd0);
    check("t3_dir", 32'(dir), 32'd0);
    guard = 0;
    while (m_turns != 16'd3 && guard < 600) begin
      hold(cur + 2, 5);
      guard++;
    end
    hold(cur, 8);
    check("t3_three_turns", 32'(turns), 32'd3);
    clr_turns = 1'b1; cycle(); clr_turns = 1'b0;
    check("t3_cleared", 32'(turns), 32'd0);

    // T6 reset while tracking at turns=2, pos=100
    guard = 0;
    while (m_turns != 16'd2 && guard < 600) begin
      hold(cur + 2, 5);
      guard++;
    end
    while (cur != 99 && guard < 1200) begin
      hold(cur + 2, 5);
      guard++;
    end
    hold(99, 8);
    hold(100, 8);
    check("t6_pre_turns", 32'(turns), 32'd2);
    check("t6_pre_pos", 32'(pos), 32'd100);
    #3 rst = 1'b1;
    #1;
    check("t6_rst_pos", 32'(pos), 32'd0);
    check("t6_rst_turns", 32'(turns), 32'd0);
    check("t6_rst_valid", 32'(pos_valid), 32'd0);
    check("t6_rst_err", 32'(jump_err), 32'd0);
    check("t6_rst_dir", 32'(dir), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    base = step_seen;
    hold(100, 10);
    check("t6_reacq_pos", 32'(pos), 32'd100);
    check("t6_reacq_valid", 32'(pos_valid), 32'd1);
    check("t6_reacq_turns", 32'(turns), 32'd0);
    check("t6_reacq_no_step", 32'(step_seen - base), 32'd0);

    // Random walk with glitches, jumps, wraps, pulses and occasional reset
    for (int seg = 0; seg < 700; seg++) begin
      int r, nxt, len;
      r = $urandom_range(0, 99);
      if (r < 70) begin
        nxt = cur + $urandom_range(1, 2) * ($urandom_range(0, 1) ? 1 : -1);
      end else if (r < 80) begin
        nxt = $urandom_range(0, 1) ? $urandom_range(250, 255) : $urandom_range(0, 5);
      end else if (r < 90) begin
        nxt = $urandom_range(0, 255);
      end else begin
        nxt = cur;
      end
      set_pos(nxt & 255);
      len = $urandom_range(1, 8);
      for (int c = 0; c < len; c++) begin
        clr_turns = ($urandom_range(0, 15) == 0);
        err_clr   = ($urandom_range(0, 11) == 0);
        cycle();
        clr_turns = 1'b0;
        err_clr   = 1'b0;
      end
      if ($urandom_range(0, 199) == 0) async_reset(1);
    end
    hold(cur, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
